alu_muldiv: RTL

Iterative multiply/divide unit for the execute stage, next to the single-cycle ALU. It covers the M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at parametrised width, one bit per cycle. Operands enter and results leave through valid/ready handshakes. A destination tag is carried alongside each operation, and a flush input kills an operation in flight.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_sign_fix.sv | 20 ++
 rtl/alu_muldiv.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and operation-decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE, S_BUSY, S_DONE
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic a_signed(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Two-lane conditional two's-complement negation; used both to take operand
// magnitudes and to restore result signs.
module muldiv_sign_fix #(
  parameter int XW = 32,
  parameter int YW = 32
) (
  input  logic [XW-1:0] x_i,
  input  logic          neg_x_i,
  input  logic [YW-1:0] y_i,
  input  logic          neg_y_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o
);

  always_comb begin
    x_o = neg_x_i ? -x_i : x_i;
    y_o = neg_y_i ? -y_i : y_i;
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative M-extension multiply/divide, one bit per cycle, valid/ready on both sides.
// Build option: MULDIV_FAST_PATH_EN finishes divide-by-zero / signed overflow on the accept edge.
module alu_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  muldiv_op_e       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  muldiv_state_e      state_q, state_d;
  muldiv_op_e         op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d, div0_q, div0_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;

  logic             in_neg_a, in_neg_b, in_div0;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, rem_sh, diff;

  assign in_neg_a = a_signed(in_op) & in_a[WIDTH-1];
  assign in_neg_b = b_signed(in_op) & in_b[WIDTH-1];
  assign in_div0  = is_div(in_op) && (in_b == ZERO);

`ifdef MULDIV_FAST_PATH_EN
  logic in_ovf;
  assign in_ovf = is_div(in_op) && a_signed(in_op) &&
                  (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (in_b == {WIDTH{1'b1}});
`endif

  muldiv_sign_fix #(.XW(WIDTH), .YW(WIDTH)) u_fix_in (
    .x_i(in_a), .neg_x_i(in_neg_a), .y_i(in_b), .neg_y_i(in_neg_b),
    .x_o(mag_a), .y_o(mag_b)
  );

  // acc_q holds {product_hi, multiplier} for multiply, {remainder, dividend/quotient} for divide
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {1'b0, ZERO});
  assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff    = rem_sh - {1'b0, opb_q};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    div0_d  = div0_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          op_d    = in_op;
          tag_d   = in_tag;
          neg_a_d = in_neg_a;
          neg_b_d = in_neg_b;
          div0_d  = in_div0;
          cnt_d   = CW'(WIDTH);
          state_d = S_BUSY;
          if (is_div(in_op)) begin
            acc_d = {ZERO, mag_a};
            opb_d = mag_b;
          end else begin
            acc_d = {ZERO, mag_b};
            opb_d = mag_a;
          end
`ifdef MULDIV_FAST_PATH_EN
          // Preload what the iterations would have produced: remainder |a|, quotient all ones
          if (in_div0 || in_ovf) state_d = S_DONE;
          if (in_div0) acc_d = {mag_a, {WIDTH{1'b1}}};
`endif
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div(op_q)) begin
          if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    neg_a_q <= neg_a_d;
    neg_b_q <= neg_b_d;
    div0_q  <= div0_d;
    cnt_q   <= cnt_d;
    acc_q   <= acc_d;
    opb_q   <= opb_d;
  end

  logic [2*WIDTH-1:0] fix_x_in, fix_x;
  logic [WIDTH-1:0]   fix_y;

  assign fix_x_in = is_div(op_q) ? {ZERO, acc_q[WIDTH-1:0]} : acc_q;

  muldiv_sign_fix #(.XW(2*WIDTH), .YW(WIDTH)) u_fix_out (
    .x_i(fix_x_in), .neg_x_i(neg_a_q ^ neg_b_q),
    .y_i(acc_q[2*WIDTH-1:WIDTH]), .neg_y_i(neg_a_q),
    .x_o(fix_x), .y_o(fix_y)
  );

  always_comb begin
    out_result = '0;
    if (state_q == S_DONE) begin
      case (op_q)
        OP_MUL:                     out_result = fix_x[WIDTH-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: out_result = fix_x[2*WIDTH-1:WIDTH];
        OP_DIV, OP_DIVU:            out_result = div0_q ? {WIDTH{1'b1}} : fix_x[WIDTH-1:0];
        default:                    out_result = fix_y;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_tag   = tag_q;

endmodule
